// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path:
// FSM states, opcodes and datapath mux/ALU selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG   = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_maindec.sv
// Multicycle MIPS main control FSM with memory handshake,
// illegal-opcode trap/skip and a retired-instruction counter.
module multicycle_maindec
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE   = 1,
  parameter int TRAP_ON_ILLEGAL = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             branch,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic             illegal_op,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt
);

  logic [3:0] state;
  logic [3:0] state_nx;
  logic [3:0] dec_nx;
  logic       legal;
  logic       rdy;
  logic       ill_nx;

  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  // Opcode dispatch out of DECODE
  always_comb begin
    legal  = 1'b1;
    dec_nx = S_FETCH;
    case (op)
      OP_RTYPE: dec_nx = S_RTEX;
      OP_LW:    dec_nx = S_MEMADR;
      OP_SW:    dec_nx = S_MEMADR;
      OP_BEQ:   dec_nx = S_BEQEX;
      OP_ADDI:  dec_nx = S_ADDIEX;
      OP_J:     dec_nx = S_JEX;
      default: begin
        legal  = 1'b0;
        dec_nx = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
      end
    endcase
  end

  // Next-state logic; memory states wait on rdy
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:  state_nx = rdy ? S_DECODE : S_FETCH;
      S_DECODE: state_nx = dec_nx;
      S_MEMADR: state_nx = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nx = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nx = rdy ? S_FETCH : S_MEMWR;
      S_RTEX:   state_nx = S_RTWB;
      S_ADDIEX: state_nx = S_ADDIWB;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Sticky while trapped; single pulse after a skipped opcode
  assign ill_nx = (state_nx == S_TRAP) ||
                  (state == S_DECODE && !legal);

  // State, illegal flag and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      illegal_op  <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state      <= state_nx;
      illegal_op <= ill_nx;
      if (retire)
        retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // Per-state datapath controls
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = ALUB_REG;
    pcsrc    = PC_ALU;
    aluop    = ALUOP_ADD;
    retire   = 1'b0;
    unique case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = ALUB_FOUR;
        irwrite = rdy;
        pcwrite = rdy;
      end
      S_DECODE: alusrcb = ALUB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        retire   = rdy;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
        retire  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_JEX: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
        retire  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Directed bench for multicycle_maindec: per-cycle vector
// table plus reset, skip-mode and counter-wrap sequences.
module tb_multicycle_maindec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, mem_ready;
  logic [5:0] op;
  logic pcwrite, branch, iord, memread, memwrite, irwrite;
  logic regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic illegal_op, retire;
  logic [31:0] retired_cnt;

  logic       reset2, mem_ready2;
  logic [5:0] op2;
  logic pcwrite2, branch2, iord2, memread2, memwrite2, irwrite2;
  logic regdst2, memtoreg2, regwrite2, alusrca2;
  logic [1:0] alusrcb2, pcsrc2, aluop2;
  logic illegal_op2, retire2;
  logic [1:0] retired_cnt2;

  multicycle_maindec dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .aluop(aluop), .illegal_op(illegal_op), .retire(retire),
    .retired_cnt(retired_cnt)
  );

  multicycle_maindec #(
    .MEM_HANDSHAKE(0), .TRAP_ON_ILLEGAL(0), .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset(reset2), .op(op2), .mem_ready(mem_ready2),
    .pcwrite(pcwrite2), .branch(branch2), .iord(iord2),
    .memread(memread2), .memwrite(memwrite2), .irwrite(irwrite2),
    .regdst(regdst2), .memtoreg(memtoreg2), .regwrite(regwrite2),
    .alusrca(alusrca2), .alusrcb(alusrcb2), .pcsrc(pcsrc2),
    .aluop(aluop2), .illegal_op(illegal_op2), .retire(retire2),
    .retired_cnt(retired_cnt2)
  );

  logic [17:0] ctl;
  assign ctl = {pcwrite, branch, iord, memread, memwrite,
                irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, aluop, illegal_op, retire};

  // pw br iord mr mw ir rd m2r rw asa | asb pcs aop | ill ret
  localparam logic [17:0] C_F1  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_F0  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DEC = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_MA  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MR  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_WB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1;
  localparam logic [17:0] C_MW0 = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MW1 = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1;
  localparam logic [17:0] C_RTE = 18'b0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
  localparam logic [17:0] C_RTW = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
  localparam logic [17:0] C_BEQ = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
  localparam logic [17:0] C_AE  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_AW  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_1;
  localparam logic [17:0] C_J   = 18'b1_0_0_0_0_0_0_0_0_0_00_10_00_0_1;
  localparam logic [17:0] C_TRP = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BQ = 6'b000100;
  localparam logic [5:0] AD = 6'b001000, JM = 6'b000010;
  localparam logic [5:0] IL = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int pass_n = 0;
  int total_n = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [5:0] o, input logic r,
                     input logic [3:0] s, input logic [17:0] c,
                     input logic [31:0] n);
    vec_t v;
    v.op = o; v.rdy = r; v.st = s; v.ctl = c; v.cnt = n;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = LW;
    reset2 = 1'b1; mem_ready2 = 1'b0; op2 = IL;

    // lw: 5 cycles
    add(LW,1,0,C_F1,0); add(LW,1,1,C_DEC,0); add(LW,1,2,C_MA,0);
    add(LW,1,3,C_MR,0); add(LW,1,4,C_WB,0);
    // sw with 3 stall cycles in MEMWR
    add(SW,1,0,C_F1,1); add(SW,1,1,C_DEC,1); add(SW,1,2,C_MA,1);
    add(SW,0,5,C_MW0,1); add(SW,0,5,C_MW0,1); add(SW,0,5,C_MW0,1);
    add(SW,1,5,C_MW1,1);
    // R-type, addi, beq, j back to back (14 cycles)
    add(RT,1,0,C_F1,2); add(RT,1,1,C_DEC,2);
    add(RT,1,6,C_RTE,2); add(RT,1,7,C_RTW,2);
    add(AD,1,0,C_F1,3); add(AD,1,1,C_DEC,3);
    add(AD,1,9,C_AE,3); add(AD,1,10,C_AW,3);
    add(BQ,1,0,C_F1,4); add(BQ,1,1,C_DEC,4); add(BQ,1,8,C_BEQ,4);
    add(JM,1,0,C_F1,5); add(JM,1,1,C_DEC,5); add(JM,1,11,C_J,5);
    // FETCH stalled two cycles
    add(AD,0,0,C_F0,6); add(AD,0,0,C_F0,6); add(AD,1,0,C_F1,6);
    add(AD,1,1,C_DEC,6); add(AD,1,9,C_AE,6); add(AD,1,10,C_AW,6);
    // illegal opcode traps and sticks
    add(IL,1,0,C_F1,7); add(IL,1,1,C_DEC,7); add(IL,1,12,C_TRP,7);
    add(IL,0,12,C_TRP,7); add(LW,1,12,C_TRP,7);

    step(); step();
    chk("reset_state", {28'd0, dut.state}, 32'd0);
    chk("reset_cnt", retired_cnt, 32'd0);
    chk("reset_ill_ret", {30'd0, illegal_op, retire}, 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      op = tbl[i].op;
      mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_state", i), {28'd0, dut.state},
          {28'd0, tbl[i].st});
      chk($sformatf("v%0d_ctl", i), {14'd0, ctl},
          {14'd0, tbl[i].ctl});
      chk($sformatf("v%0d_cnt", i), retired_cnt, tbl[i].cnt);
      step();
    end

    // reset out of TRAP
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("trap_rst_state", {28'd0, dut.state}, 32'd0);
    chk("trap_rst_ill", {31'd0, illegal_op}, 32'd0);
    chk("trap_rst_cnt", retired_cnt, 32'd0);

    // reset during a stalled MEMRD
    op = LW; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    #1;
    chk("memrd_stall_state", {28'd0, dut.state}, 32'd3);
    chk("memrd_stall_rw", {31'd0, regwrite}, 32'd0);
    step();
    reset = 1'b1;
    #1;
    chk("memrd_rst_rw", {31'd0, regwrite}, 32'd0);
    step();
    reset = 1'b0;
    chk("memrd_rst_state", {28'd0, dut.state}, 32'd0);
    chk("memrd_rst_cnt", retired_cnt, 32'd0);
    chk("memrd_rst_rw2", {31'd0, regwrite}, 32'd0);
    mem_ready = 1'b1;
    step();
    chk("memrd_rst_dec", {28'd0, dut.state}, 32'd1);

    // skip mode, handshake ignored, 2-bit counter
    reset2 = 1'b0;
    #1;
    chk("skip_fetch_ir", {30'd0, irwrite2, pcwrite2}, 32'd3);
    step();
    chk("skip_dec_ill", {31'd0, illegal_op2}, 32'd0);
    step();
    chk("skip_state", {28'd0, dut2.state}, 32'd0);
    chk("skip_pulse", {31'd0, illegal_op2}, 32'd1);
    chk("skip_cnt", {30'd0, retired_cnt2}, 32'd0);
    op2 = JM;
    step();
    chk("skip_pulse_end", {31'd0, illegal_op2}, 32'd0);
    step();
    chk("skip_jex_ret", {31'd0, retire2}, 32'd1);
    step();
    chk("wrap_c1", {30'd0, retired_cnt2}, 32'd1);
    for (int k = 2; k <= 5; k++) begin
      step(); step(); step();
      chk($sformatf("wrap_c%0d", k), {30'd0, retired_cnt2},
          32'(k % 4));
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/multicycle_maindec.md
Name: multicycle_maindec

Overview:
- Multicycle control FSM; successor to the single-cycle main decoder. Sequences each MIPS instruction over 3–5 states and drives datapath enables/muxes per state.
- Adds variable-latency memory handshake, illegal-opcode trap/skip mode, and a retired-instruction counter.
- Sits between the instruction register opcode field and the shared multicycle datapath; ALU decoder unchanged.

Parameters:
- MEM_HANDSHAKE, 1, 1: FETCH/MEMRD/MEMWR stall until mem_ready=1; 0: mem_ready ignored, treated as 1.
- TRAP_ON_ILLEGAL, 1, 1: illegal op enters sticky TRAP; 0: illegal op is skipped as a NOP (DECODE→FETCH).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  opcode from instruction register, sampled in DECODE.
- mem_ready  in  1  memory completes current access this cycle.
- pcwrite  out  1  unconditional PC write.
- branch  out  1  conditional PC write (datapath ANDs with zero).
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  instruction register load.
- regdst  out  1  write register select: 1=rd, 0=rt.
- memtoreg  out  1  write-back select: 1=data register, 0=ALUOut.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A select: 0=PC, 1=register A.
- alusrcb  out  2  ALU B select: 00=B, 01=4, 10=signext imm, 11=signext imm<<2.
- pcsrc  out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target.
- aluop  out  2  to ALU decoder: 00 add, 01 sub, 10 funct.
- illegal_op  out  1  TRAP mode: sticky, set on entry to TRAP; skip mode: 1-cycle pulse.
- retire  out  1  1-cycle pulse on last state of each legal instruction.
- retired_cnt  out  CNT_W  count of retire pulses; wraps to 0 modulo 2^CNT_W.

Behaviour:
- State register, 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, TRAP=12. Unused encodings go to FETCH.
- Reset (sync): state=FETCH, illegal_op=0, retired_cnt=0, retire=0. Outputs follow FETCH decode in the first post-reset cycle. Reset during any state, including a stalled memory access, aborts to FETCH at that edge; no partial write-back.
- Outputs are Moore on state. Exceptions: irwrite and pcwrite in FETCH, which are gated by mem_ready (Mealy). Unlisted outputs are 0.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 000000 → RTEX
  - 100011 → MEMADR
  - 101011 → MEMADR
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - any other op → TRAP if TRAP_ON_ILLEGAL=1, else FETCH with an illegal_op pulse.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state: MEMRD for lw, MEMWR for sw. op must be held stable by the IR.
- MEMRD: iord=1, memread=1. Stays until mem_ready=1, then MEMWB.
- MEMWB: memtoreg=1, regwrite=1, retire=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1. Stays until mem_ready=1; on completion retire=1 and next state FETCH. memwrite is held asserted for the whole stall.
- RTEX: alusrca=1, alusrcb=00, aluop=10 → RTWB.
- RTWB: regdst=1, regwrite=1, retire=1 → FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, retire=1 → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWB.
- ADDIWB: regwrite=1, retire=1 → FETCH.
- JEX: pcsrc=10, pcwrite=1, retire=1 → FETCH.
- TRAP: all enables 0, illegal_op=1; exits only via reset.
- retired_cnt increments by 1 on each cycle with retire=1; no saturation.
- Latency in cycles with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Decomposition:
- Package mips_ctrl_pkg: state enum typedef, 6-bit opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), aluop and alusrcb/pcsrc encoding constants. Shared with the ALU decoder and datapath.
- No sub-module. The output decode is a single combinational case on state inside this module.

Test Plan:
- reset, mem_ready=1, op=100011 → states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; retired_cnt=1.
- op=101011, mem_ready low for 3 cycles in MEMWR → memwrite high for 4 cycles, iord=1; retire pulses once; no regwrite.
- Sequence R-type, addi, beq, j with mem_ready=1 → 4+4+3+3=14 cycles; retired_cnt=4; JEX has pcsrc=10, pcwrite=1; BEQEX has branch=1, aluop=01.
- FETCH with mem_ready=0 for 2 cycles → irwrite=pcwrite=0 while stalled, 1 on the ready cycle; DECODE entered on the following edge.
- op=111111: TRAP_ON_ILLEGAL=1 → state 12, illegal_op stuck at 1, retired_cnt unchanged until reset. TRAP_ON_ILLEGAL=0 → returns to FETCH, illegal_op pulses 1 cycle.
- reset asserted in MEMRD mid-stall → FETCH next cycle, retired_cnt=0, no regwrite. Also: CNT_W=2 with 5 retires → retired_cnt=1 (wrap).
